// File: rtl/proc_trace_fifo_if.sv
// ============================================================================
// Module      : proc_trace_fifo_if
// Description : Capture-side and read-side signal bundle for proc_trace_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface proc_trace_fifo_if #(
    parameter int DEPTH = 16,
    parameter int W     = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          Cap_En;
    logic          Cap_Mode;
    logic [W-1:0]  ALU_Out;
    logic [W-1:0]  MEM_Out;
    logic [W-1:0]  RFrd;
    logic          Rd_Valid;
    logic          Rd_Ready;
    logic [W-1:0]  Rd_ALU;
    logic [W-1:0]  Rd_MEM;
    logic [W-1:0]  Rd_RF;
    logic [15:0]   Rd_Stamp;
    logic [CW-1:0] Count;
    logic          Overflow;
    logic [7:0]    Drop_Cnt;

    modport slave (
        input  Cap_En, Cap_Mode, ALU_Out, MEM_Out, RFrd, Rd_Ready,
        output Rd_Valid, Rd_ALU, Rd_MEM, Rd_RF, Rd_Stamp, Count, Overflow, Drop_Cnt
    );

    modport master (
        output Cap_En, Cap_Mode, ALU_Out, MEM_Out, RFrd, Rd_Ready,
        input  Rd_Valid, Rd_ALU, Rd_MEM, Rd_RF, Rd_Stamp, Count, Overflow, Drop_Cnt
    );
endinterface

`default_nettype wire

// File: rtl/proc_trace_fifo.sv
// ============================================================================
// Module      : proc_trace_fifo
// Description : Timestamped FIFO trace capture of processor result buses with
//               first-word fall-through valid/ready drain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    proc_trace_fifo_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = 3 * W;
    localparam int EW = TW + 16;

    logic [15:0]   cyc_q;
    logic [TW-1:0] prev_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;
    logic [7:0]    drop_q;
    logic [EW-1:0] mem_q [DEPTH];

    logic [TW-1:0] w_triple;
    logic          w_cap;
    logic          w_full;
    logic          w_not_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_triple    = {bus.ALU_Out, bus.MEM_Out, bus.RFrd};
    assign w_cap       = bus.Cap_En && (!bus.Cap_Mode || (w_triple != prev_q));
    assign w_full      = (count_q == CW'(DEPTH));
    assign w_not_empty = (count_q != '0);
    assign w_pop       = w_not_empty && bus.Rd_Ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push      = w_cap && (!w_full || w_pop);
    assign w_drop      = w_cap && w_full && !w_pop;

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + CW'(1);
        end else if (w_pop && !w_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cyc_q    <= '0;
            prev_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            cyc_q   <= cyc_q + 16'd1;
            count_q <= count_d;
            if (bus.Cap_En) begin
                prev_q <= w_triple;
            end
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (w_drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_q <= drop_q + 8'd1;
                end
            end
        end
    end

    // Storage is cleared on reset so the read fields show zero afterwards.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_push) begin
            mem_q[wr_ptr_q] <= {w_triple, cyc_q};
        end
    end

    assign bus.Rd_Valid = w_not_empty;
    assign {bus.Rd_ALU, bus.Rd_MEM, bus.Rd_RF, bus.Rd_Stamp} = mem_q[rd_ptr_q];
    assign bus.Count    = count_q;
    assign bus.Overflow = ovf_q;
    assign bus.Drop_Cnt = drop_q;

endmodule

`default_nettype wire

// File: doc/proc_trace_fifo.md
# proc_trace_fifo

Capture buffer on the observation side of `processor`. Samples the processor's per-cycle result buses (`ALU_Out`, `MEM_Out`, `RFrd`) on `Clk` and stores each sample with a cycle timestamp in a FIFO. A bench or debug port drains the FIFO over a valid/ready read handshake. It replaces hand-inspection of waveforms with a checkable, ordered trace.

## Interface

- `DEPTH`, 16: FIFO entries; must be a power of 2, minimum 2.
- `W`, 32: width of each captured bus.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Cap_En`  in  1  capture enable; no sample is taken while low.
- `Cap_Mode`  in  1  0 = capture every enabled cycle; 1 = capture only on change.
- `ALU_Out`  in  W  processor ALU result.
- `MEM_Out`  in  W  processor memory read data.
- `RFrd`  in  W  processor register-file read data.
- `Rd_Valid`  out  1  head entry present (FIFO not empty).
- `Rd_Ready`  in  1  consumer accepts the head entry.
- `Rd_ALU`, `Rd_MEM`, `Rd_RF`  out  W each  head entry fields.
- `Rd_Stamp`  out  16  cycle stamp of the head entry.
- `Count`  out  log2(DEPTH)+1  current occupancy.
- `Overflow`  out  1  sticky; set when a sample is dropped.
- `Drop_Cnt`  out  8  dropped-sample counter; saturates at 255.

## Operation

- Cycle counter: 16-bit, free-running from reset, +1 every edge, wraps 0xFFFF→0x0000. A sample's stamp is the counter value before that edge's increment.
- Previous-sample register: holds {ALU_Out, MEM_Out, RFrd}; reset to all zeros. Loaded on every edge where `Cap_En`=1, whether or not the sample is accepted.
- Capture condition: `Cap_En` && (`Cap_Mode`=0 || current triple ≠ previous-sample register). After reset, change mode compares against zero.
- Push: capture condition && (not full || pop this edge). The entry written is {ALU_Out, MEM_Out, RFrd, stamp}.
- Drop: capture condition && full && no pop. On a drop, `Overflow`←1 and `Drop_Cnt`+1, saturating at 255. FIFO contents are unchanged.
- Pop: `Rd_Valid` && `Rd_Ready`. The head pointer advances. `Rd_Ready` is ignored while `Rd_Valid`=0.
- Storage: circular buffer with wr/rd pointers of log2(DEPTH) bits; pointers wrap DEPTH-1→0. `Count` is explicit: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full = (`Count`==DEPTH); empty = (`Count`==0).
- Read is first-word fall-through: `Rd_*` always show the entry at the read pointer. They are don't-care when empty.
- `Overflow` and `Drop_Cnt` clear only on `Reset`.
- Reset (asynchronous, any time, including mid-drain): `Count`=0, pointers=0, `Rd_Valid`=0, `Overflow`=0, `Drop_Cnt`=0, cycle counter=0, previous-sample register=0. `Rd_ALU`/`Rd_MEM`/`Rd_RF`/`Rd_Stamp` read 0 because storage is cleared. Any in-flight pop is discarded.

## Timing

- Capture latency: a sample taken at edge N is visible (`Rd_Valid`=1, data on `Rd_*`) after edge N when the FIFO was empty.
- Pop latency: after a pop at edge N, the next entry is on `Rd_*` after edge N.
- Full with simultaneous push and pop: the push is accepted, `Count` stays DEPTH, and no drop occurs.
- Empty with push and `Rd_Ready`=1: no pop happens; `Count` becomes 1.
- Sustained throughput: one push and one pop per cycle.
- The stamp wraps silently; consumers handle modulo-65536 ordering.

## Test plan

- Reset, then `Cap_En`=1, `Cap_Mode`=0, `Rd_Ready`=0, with ALU_Out=1,2,3 on edges 0–2 → `Count`=3, `Rd_ALU`=1, `Rd_Stamp`=0. Then `Rd_Ready`=1 for 3 cycles → ALU values 1,2,3 with stamps 0,1,2, then `Rd_Valid`=0.
- `Cap_Mode`=1, inputs held at 0x5 for 4 cycles, then 0x6 → exactly 2 entries (0x5, 0x6). An initial all-zero input produces no entry.
- DEPTH=16, `Rd_Ready`=0, 20 enabled cycles → `Count`=16, `Overflow`=1, `Drop_Cnt`=4. Draining yields the first 16 samples in order.
- Full FIFO with `Rd_Ready`=1 and capture active for 10 cycles → `Count` stays 16 and `Drop_Cnt` is unchanged.
- 300 drops → `Drop_Cnt`=255 (saturated).
- Run 65540 cycles, capturing at cycles 65535 and 65536 → stamps 0xFFFF then 0x0000. Assert `Reset` mid-drain → on that edge `Rd_Valid`=0, `Count`=0, `Overflow`=0, and stamps restart at 0.
